// File: rtl/piradip_sync_fifo_gen_pkg.sv
// Shared types and elaboration helpers for the piradip sync FIFO family.
package piradip_fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_t;

  localparam int MIN_DEPTH = 4;
  localparam int MAX_DEPTH = 65536;

  // Count needs one extra bit so that DEPTH itself is representable.
  function automatic int fifo_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int depth);
    return (depth > 0) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit depth_ok(input int depth);
    return is_pow2(depth) && (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH);
  endfunction

endpackage

// File: rtl/piradip_sync_fifo_gen_if.sv
// FIFO write/read/status bundle. Sticky error bits exist only when
// PIRADIP_SYNC_FIFO_STICKY_ERR_EN is defined.
interface piradip_sync_fifo_gen_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int CW = piradip_fifo_pkg::fifo_cw(DEPTH);

  logic             we;
  logic [WIDTH-1:0] din;
  logic             wr_ack;
  logic             overflow;
  logic             re;
  logic [WIDTH-1:0] dout;
  logic             data_valid;
  logic             underflow;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             prog_full;
  logic             prog_empty;
  logic [CW-1:0]    count;
`ifdef PIRADIP_SYNC_FIFO_STICKY_ERR_EN
  logic             err_clr;
  logic [1:0]       err_status;
`endif

  // FIFO side
  modport slave (
    input  we, din, re,
`ifdef PIRADIP_SYNC_FIFO_STICKY_ERR_EN
    input  err_clr,
    output err_status,
`endif
    output wr_ack, overflow, dout, data_valid, underflow, full, empty,
           almost_full, almost_empty, prog_full, prog_empty, count
  );

  // Producer/consumer side
  modport master (
    output we, din, re,
`ifdef PIRADIP_SYNC_FIFO_STICKY_ERR_EN
    output err_clr,
    input  err_status,
`endif
    input  wr_ack, overflow, dout, data_valid, underflow, full, empty,
           almost_full, almost_empty, prog_full, prog_empty, count
  );

endinterface

// File: rtl/piradip_sdp_ram.sv
// Simple dual-port RAM, one clock, registered synchronous read.
module piradip_sdp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;

  // read port; output register holds between reads
  always_ff @(posedge clk)
    if (rd_en) rd_data <= mem[rd_addr];

endmodule

// File: rtl/piradip_sync_fifo_gen.sv
// Native synchronous FIFO, standard or first-word-fall-through read.
// Optional sticky error status: define PIRADIP_SYNC_FIFO_STICKY_ERR_EN.
// dout is a mux between the RAM read register and a bypass register; the
// bypass carries FWFT writes that land in an otherwise empty FIFO and is
// held at zero in standard mode so dout reads 0 until the first pop.
module piradip_sync_fifo_gen
  import piradip_fifo_pkg::*;
#(
  parameter int WIDTH             = 32,
  parameter int DEPTH             = 16,
  parameter int FWFT              = 0,
  parameter int PROG_FULL_THRESH  = DEPTH - 2,
  parameter int PROG_EMPTY_THRESH = 2
) (
  input logic                    clk,
  input logic                    rstn,
  piradip_sync_fifo_gen_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cw(DEPTH);
  localparam fifo_mode_t MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - 1);
  localparam logic [CW-1:0] PF_TH    = CW'(PROG_FULL_THRESH);
  localparam logic [CW-1:0] PE_TH    = CW'(PROG_EMPTY_THRESH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("piradip_sync_fifo_gen: DEPTH must be a power of two in 4..65536");
  end

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q, count_nxt;
  logic             full_q, empty_q, afull_q, aempty_q, pfull_q, pempty_q;
  logic             wr_ack_q, ovf_q, unf_q, dv_q;
  logic             wr_acc, rd_acc, byp_load, ram_we, ram_re;
  logic             use_ram_q;
  logic [WIDTH-1:0] byp_q, ram_q;

  // Accept decisions, FWFT bypass steering and post-update count.
  // In FWFT the RAM holds count-1 words (head lives in the output stage),
  // so a pop only pulls from RAM when more than one word is held.
  always_comb begin
    wr_acc   = rstn & bus.we & ~full_q;
    rd_acc   = rstn & bus.re & ~empty_q;
    byp_load = 1'b0;
    ram_re   = rd_acc;
    if (MODE == FIFO_FWFT) begin
      byp_load = wr_acc & ((count_q == '0) | ((count_q == CW'(1)) & rd_acc));
      ram_re   = rd_acc & (count_q > CW'(1));
    end
    ram_we    = wr_acc & ~byp_load;
    count_nxt = count_q;
    if (wr_acc & ~rd_acc)      count_nxt = count_q + 1'b1;
    else if (rd_acc & ~wr_acc) count_nxt = count_q - 1'b1;
  end

  // RAM pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (ram_we) wr_ptr <= wr_ptr + 1'b1;
      if (ram_re) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
    end
  end

  // Status flags, registered from the post-update count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b0;
      pfull_q  <= 1'b0;
      pempty_q <= 1'b1;
    end else begin
      full_q   <= (count_nxt == FULL_CNT);
      empty_q  <= (count_nxt == '0);
      afull_q  <= (count_nxt == AF_CNT);
      aempty_q <= (count_nxt == CW'(1));
      pfull_q  <= (count_nxt >= PF_TH);
      pempty_q <= (count_nxt <= PE_TH);
    end
  end

  // One-cycle handshake/error pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      wr_ack_q <= wr_acc;
      ovf_q    <= bus.we & full_q;
      unf_q    <= bus.re & empty_q;
      dv_q     <= rd_acc;
    end
  end

  // Output stage: pick bypass word or RAM read register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byp_q     <= '0;
      use_ram_q <= 1'b0;
    end else if (byp_load) begin
      byp_q     <= bus.din;
      use_ram_q <= 1'b0;
    end else if (ram_re) begin
      use_ram_q <= 1'b1;
    end
  end

  piradip_sdp_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr),
    .wr_data (bus.din),
    .rd_en   (ram_re),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

`ifdef PIRADIP_SYNC_FIFO_STICKY_ERR_EN
  logic [1:0] err_q;

  // Sticky error bits; a new error beats a simultaneous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= '0;
    else begin
      err_q[0] <= (bus.we & full_q)  | (err_q[0] & ~bus.err_clr);
      err_q[1] <= (bus.re & empty_q) | (err_q[1] & ~bus.err_clr);
    end
  end

  assign bus.err_status = err_q;
`endif

  assign bus.dout         = use_ram_q ? ram_q : byp_q;
  assign bus.data_valid   = (MODE == FIFO_FWFT) ? ~empty_q : dv_q;
  assign bus.wr_ack       = wr_ack_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.prog_full    = pfull_q;
  assign bus.prog_empty   = pempty_q;
  assign bus.count        = count_q;

endmodule

// File: tb/tb_piradip_sync_fifo_gen.sv
// Bench for piradip_sync_fifo_gen: a standard-mode and an FWFT instance
// receive identical stimulus and are compared against a queue model.
module tb_piradip_sync_fifo_gen;
  import piradip_fifo_pkg::*;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int CW = fifo_cw(D);

  typedef logic [CW+8:0] flg_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  piradip_sync_fifo_gen_if #(.WIDTH(W), .DEPTH(D)) if_s ();
  piradip_sync_fifo_gen_if #(.WIDTH(W), .DEPTH(D)) if_f ();

  piradip_sync_fifo_gen #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
    .clk(clk), .rstn(rstn), .bus(if_s.slave));
  piradip_sync_fifo_gen #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
    .clk(clk), .rstn(rstn), .bus(if_f.slave));

  flg_t f_s, f_f;
  assign f_s = {if_s.full, if_s.empty, if_s.almost_full, if_s.almost_empty,
                if_s.prog_full, if_s.prog_empty, if_s.wr_ack, if_s.overflow,
                if_s.underflow, if_s.count};
  assign f_f = {if_f.full, if_f.empty, if_f.almost_full, if_f.almost_empty,
                if_f.prog_full, if_f.prog_empty, if_f.wr_ack, if_f.overflow,
                if_f.underflow, if_f.count};

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: contents as a queue plus last-cycle pulses
  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout_std;
  bit m_dv_std, m_wack, m_ovf, m_unf;

  function automatic void model_reset();
    mq.delete();
    m_dout_std = '0;
    m_dv_std = 0; m_wack = 0; m_ovf = 0; m_unf = 0;
  endfunction

  function automatic void model_step(bit we, logic [W-1:0] d, bit re);
    int  n  = mq.size();
    bit  wa = we && (n < D);
    bit  ra = re && (n > 0);
    m_wack   = wa;
    m_ovf    = we && !wa;
    m_unf    = re && (n == 0);
    m_dv_std = ra;
    if (ra) m_dout_std = mq.pop_front();
    if (wa) mq.push_back(d);
  endfunction

  function automatic flg_t exp_flags();
    int n = mq.size();
    return {n == D, n == 0, n == D - 1, n == 1, n >= D - 2, n <= 2,
            m_wack, m_ovf, m_unf, CW'(n)};
  endfunction

  task automatic drive_idle();
    if_s.we = 0; if_s.din = '0; if_s.re = 0;
    if_f.we = 0; if_f.din = '0; if_f.re = 0;
`ifdef PIRADIP_SYNC_FIFO_STICKY_ERR_EN
    if_s.err_clr = 0; if_f.err_clr = 0;
`endif
  endtask

  // one clock of identical stimulus to both DUTs; returns at posedge+1
  task automatic cyc(input bit we, input logic [W-1:0] d, input bit re);
    if_s.we = we; if_s.din = d; if_s.re = re;
    if_f.we = we; if_f.din = d; if_f.re = re;
    model_step(we, d, re);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 0;
    drive_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (f_s !== exp_flags()) begin n_fail++; $display("FAIL reset_std_flags got %h exp %h", f_s, exp_flags()); end
    n_tests++; if (f_f !== exp_flags()) begin n_fail++; $display("FAIL reset_fwft_flags got %h exp %h", f_f, exp_flags()); end
    n_tests++;
    if ({if_s.dout, if_f.dout, if_s.data_valid, if_f.data_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got std_dout=%h fwft_dout=%h dv=%b%b exp all 0",
               if_s.dout, if_f.dout, if_s.data_valid, if_f.data_valid);
    end
    rstn = 1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < D; i++) begin
      cyc(1, W'(i), 0);
      n_tests++; if (f_s !== exp_flags()) begin n_fail++; $display("FAIL fill_std_flags i=%0d got %h exp %h", i, f_s, exp_flags()); end
      n_tests++; if (f_f !== exp_flags()) begin n_fail++; $display("FAIL fill_fwft_flags i=%0d got %h exp %h", i, f_f, exp_flags()); end
      n_tests++; if (if_f.dout !== mq[0]) begin n_fail++; $display("FAIL fill_fwft_head i=%0d got %h exp %h", i, if_f.dout, mq[0]); end
    end
    cyc(1, 32'hDEAD_BEEF, 0);
    n_tests++;
    if (if_s.overflow !== 1'b1 || if_s.count !== CW'(D) || if_s.wr_ack !== 1'b0) begin
      n_fail++; $display("FAIL overflow_pulse got ovf=%b cnt=%0d ack=%b exp ovf=1 cnt=16 ack=0", if_s.overflow, if_s.count, if_s.wr_ack);
    end
    n_tests++; if (f_f !== exp_flags()) begin n_fail++; $display("FAIL overflow_fwft got %h exp %h", f_f, exp_flags()); end
    cyc(0, '0, 0);
    n_tests++; if (f_s !== exp_flags()) begin n_fail++; $display("FAIL overflow_clear got %h exp %h", f_s, exp_flags()); end
    for (int i = 0; i < D; i++) begin
      cyc(0, '0, 1);
      n_tests++; if (f_s !== exp_flags()) begin n_fail++; $display("FAIL drain_std_flags i=%0d got %h exp %h", i, f_s, exp_flags()); end
      n_tests++;
      if (if_s.dout !== W'(i) || if_s.data_valid !== 1'b1) begin
        n_fail++; $display("FAIL drain_std_data i=%0d got %h dv=%b exp %h dv=1", i, if_s.dout, if_s.data_valid, W'(i));
      end
      if (mq.size() > 0) begin
        n_tests++; if (if_f.dout !== mq[0]) begin n_fail++; $display("FAIL drain_fwft_head i=%0d got %h exp %h", i, if_f.dout, mq[0]); end
      end
    end
    cyc(0, '0, 0);
    n_tests++;
    if (if_s.data_valid !== 1'b0 || if_s.dout !== W'(D - 1)) begin
      n_fail++; $display("FAIL std_hold got %h dv=%b exp %h dv=0", if_s.dout, if_s.data_valid, W'(D - 1));
    end
  endtask

  task automatic test_underflow();
    cyc(0, '0, 1);
    n_tests++;
    if (if_s.underflow !== 1'b1 || if_s.count !== '0 || if_s.dout !== m_dout_std) begin
      n_fail++; $display("FAIL underflow_std got unf=%b cnt=%0d dout=%h exp unf=1 cnt=0 dout=%h", if_s.underflow, if_s.count, if_s.dout, m_dout_std);
    end
    n_tests++; if (f_f !== exp_flags()) begin n_fail++; $display("FAIL underflow_fwft got %h exp %h", f_f, exp_flags()); end
    cyc(0, '0, 0);
    n_tests++; if (f_s !== exp_flags()) begin n_fail++; $display("FAIL underflow_once got %h exp %h", f_s, exp_flags()); end
  endtask

  task automatic test_fwft_fallthrough();
    cyc(1, 32'hA5, 0);
    n_tests++;
    if (if_f.empty !== 1'b0 || if_f.dout !== 32'hA5 || if_f.data_valid !== 1'b1) begin
      n_fail++; $display("FAIL fwft_fall got empty=%b dout=%h dv=%b exp 0 a5 1", if_f.empty, if_f.dout, if_f.data_valid);
    end
    cyc(0, '0, 1);
    n_tests++;
    if (if_f.empty !== 1'b1 || if_f.data_valid !== 1'b0) begin
      n_fail++; $display("FAIL fwft_pop got empty=%b dv=%b exp 1 0", if_f.empty, if_f.data_valid);
    end
    n_tests++;
    if (if_s.dout !== 32'hA5 || if_s.data_valid !== 1'b1) begin
      n_fail++; $display("FAIL std_single got %h dv=%b exp a5 dv=1", if_s.dout, if_s.data_valid);
    end
  endtask

  task automatic test_stream();
    cyc(1, $urandom, 0);
    for (int i = 0; i < 1000; i++) begin
      cyc(1, $urandom, 1);
      n_tests++; if (f_f !== exp_flags()) begin n_fail++; $display("FAIL stream_fwft_flags i=%0d got %h exp %h", i, f_f, exp_flags()); end
      n_tests++;
      if (if_f.dout !== mq[0] || if_f.empty !== 1'b0) begin
        n_fail++; $display("FAIL stream_fwft_data i=%0d got %h empty=%b exp %h empty=0", i, if_f.dout, if_f.empty, mq[0]);
      end
      n_tests++;
      if (if_s.dout !== m_dout_std || if_s.data_valid !== 1'b1 || if_s.count !== CW'(1)) begin
        n_fail++; $display("FAIL stream_std i=%0d got %h dv=%b cnt=%0d exp %h dv=1 cnt=1", i, if_s.dout, if_s.data_valid, if_s.count, m_dout_std);
      end
    end
    cyc(0, '0, 1);
    n_tests++; if (f_s !== exp_flags()) begin n_fail++; $display("FAIL stream_drain got %h exp %h", f_s, exp_flags()); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < D; i++) cyc(1, $urandom, 0);
    cyc(1, $urandom, 1);
    n_tests++;
    if (if_s.overflow !== 1'b1 || if_s.wr_ack !== 1'b0 || if_s.count !== CW'(D - 1) || if_s.dout !== m_dout_std) begin
      n_fail++; $display("FAIL full_rw_std got ovf=%b ack=%b cnt=%0d dout=%h exp 1 0 15 %h", if_s.overflow, if_s.wr_ack, if_s.count, if_s.dout, m_dout_std);
    end
    n_tests++; if (f_f !== exp_flags()) begin n_fail++; $display("FAIL full_rw_fwft got %h exp %h", f_f, exp_flags()); end
    while (mq.size() > 0) begin
      cyc(0, '0, 1);
      n_tests++; if (f_s !== exp_flags()) begin n_fail++; $display("FAIL thresh_std cnt=%0d got %h exp %h", mq.size(), f_s, exp_flags()); end
      n_tests++; if (f_f !== exp_flags()) begin n_fail++; $display("FAIL thresh_fwft cnt=%0d got %h exp %h", mq.size(), f_f, exp_flags()); end
    end
  endtask

  task automatic test_random();
    int pw [6] = '{80, 30, 50, 90, 10, 60};
    int pr [6] = '{30, 80, 50, 10, 90, 60};
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 100; i++) begin
        cyc($urandom_range(99) < pw[ph], $urandom, $urandom_range(99) < pr[ph]);
        n_tests++; if (f_s !== exp_flags()) begin n_fail++; $display("FAIL rand_std_flags ph=%0d i=%0d got %h exp %h", ph, i, f_s, exp_flags()); end
        n_tests++; if (f_f !== exp_flags()) begin n_fail++; $display("FAIL rand_fwft_flags ph=%0d i=%0d got %h exp %h", ph, i, f_f, exp_flags()); end
        n_tests++;
        if (if_s.dout !== m_dout_std || if_s.data_valid !== m_dv_std) begin
          n_fail++; $display("FAIL rand_std_data ph=%0d i=%0d got %h dv=%b exp %h dv=%b", ph, i, if_s.dout, if_s.data_valid, m_dout_std, m_dv_std);
        end
        n_tests++;
        if (if_f.data_valid !== (mq.size() > 0) || (mq.size() > 0 && if_f.dout !== mq[0])) begin
          n_fail++; $display("FAIL rand_fwft_data ph=%0d i=%0d got %h dv=%b exp dv=%b", ph, i, if_f.dout, if_f.data_valid, mq.size() > 0);
        end
      end
    end
    while (mq.size() > 0) cyc(0, '0, 1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) cyc(1, $urandom, 0);
    cyc(1, $urandom, 1);
    #2;
    rstn = 0;
    model_reset();
    #1;
    n_tests++; if (f_s !== exp_flags()) begin n_fail++; $display("FAIL areset_std got %h exp %h", f_s, exp_flags()); end
    n_tests++; if (f_f !== exp_flags()) begin n_fail++; $display("FAIL areset_fwft got %h exp %h", f_f, exp_flags()); end
    n_tests++;
    if (if_s.dout !== '0 || if_f.dout !== '0) begin
      n_fail++; $display("FAIL areset_dout got %h %h exp 0 0", if_s.dout, if_f.dout);
    end
    if_s.we = 1; if_f.we = 1; if_s.din = 32'h5555; if_f.din = 32'h5555;
    @(posedge clk); #1;
    n_tests++;
    if (if_s.count !== '0 || if_f.count !== '0 || if_s.wr_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_blocks_write got cnt=%0d/%0d ack=%b exp 0/0 0", if_s.count, if_f.count, if_s.wr_ack);
    end
    drive_idle();
    rstn = 1;
    cyc(1, 32'h1234_5678, 0);
    n_tests++; if (if_f.dout !== 32'h1234_5678) begin n_fail++; $display("FAIL post_reset_fwft got %h exp 12345678", if_f.dout); end
    cyc(0, '0, 1);
    n_tests++; if (if_s.dout !== 32'h1234_5678) begin n_fail++; $display("FAIL post_reset_std got %h exp 12345678", if_s.dout); end
  endtask

`ifdef PIRADIP_SYNC_FIFO_STICKY_ERR_EN
  task automatic test_sticky();
    for (int i = 0; i < D; i++) cyc(1, $urandom, 0);
    cyc(1, $urandom, 0);
    n_tests++; if (if_s.err_status !== 2'b01 || if_f.err_status !== 2'b01) begin n_fail++; $display("FAIL sticky_set got %b %b exp 01", if_s.err_status, if_f.err_status); end
    repeat (3) cyc(0, '0, 0);
    n_tests++; if (if_s.err_status !== 2'b01) begin n_fail++; $display("FAIL sticky_hold got %b exp 01", if_s.err_status); end
    if_s.err_clr = 1; if_f.err_clr = 1;
    cyc(1, $urandom, 0);
    n_tests++; if (if_s.err_status !== 2'b01) begin n_fail++; $display("FAIL sticky_set_wins got %b exp 01", if_s.err_status); end
    cyc(0, '0, 0);
    n_tests++; if (if_s.err_status !== 2'b00 || if_f.err_status !== 2'b00) begin n_fail++; $display("FAIL sticky_clear got %b %b exp 00", if_s.err_status, if_f.err_status); end
    if_s.err_clr = 0; if_f.err_clr = 0;
    while (mq.size() > 0) cyc(0, '0, 1);
    cyc(0, '0, 1);
    n_tests++; if (if_s.err_status !== 2'b10 || if_f.err_status !== 2'b10) begin n_fail++; $display("FAIL sticky_unf got %b %b exp 10", if_s.err_status, if_f.err_status); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_underflow();
    test_fwft_fallthrough();
    test_stream();
    test_full_rw();
    test_random();
    test_async_reset();
`ifdef PIRADIP_SYNC_FIFO_STICKY_ERR_EN
    test_sticky();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/piradip_sync_fifo_gen.md
Name: piradip_sync_fifo_gen

Overview:
Native-RTL synchronous FIFO; next generation of the vendor-macro-based sync FIFO.
- Generic across width, power-of-two depth and read mode (standard or first-word-fall-through), with real occupancy counts, programmable thresholds, write-ack and data-valid.
- Sits between AXI-stream/DMA datapaths and sample-rate logic inside one clock domain, with no vendor-macro dependency.

Parameters:
WIDTH, 32, data width in bits (>=1)
DEPTH, 16, capacity in entries; power of two, 4..65536
FWFT, 0, 0 = standard read (1-cycle latency), 1 = first-word-fall-through
PROG_FULL_THRESH, DEPTH-2, prog_full asserted when count >= value (1..DEPTH)
PROG_EMPTY_THRESH, 2, prog_empty asserted when count <= value (0..DEPTH-1)
CW, $clog2(DEPTH)+1, count width (derived localparam, not overridable)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
we  in  1  write request
din  in  WIDTH  write data
wr_ack  out  1  write accepted last cycle
overflow  out  1  write rejected last cycle (we while full)
re  in  1  read request / pop
dout  out  WIDTH  read data
data_valid  out  1  dout holds valid data (STD: pulse; FWFT: equals !empty)
underflow  out  1  read rejected last cycle (re while empty)
full  out  1  count == DEPTH
empty  out  1  no readable word
almost_full  out  1  count == DEPTH-1
almost_empty  out  1  count == 1
prog_full  out  1  count >= PROG_FULL_THRESH
prog_empty  out  1  count <= PROG_EMPTY_THRESH
count  out  CW  words held (RAM plus FWFT output register)

Behaviour:
- Reset (rstn low, async assert, sync release): pointers 0, count 0, dout 0, empty 1, prog_empty 1, all other flags 0. Reset mid-transfer discards contents; no write or read is accepted while rstn is low.
- All flags are registered and derived from the post-update count.
- Accept rules:
  - Write accepted iff we && !full, with full sampled at the start of the cycle.
  - Read accepted iff re && !empty.
  - A read in the same cycle does not free space for a write when full.
- Count update per cycle: +1 on write only, -1 on read only, unchanged on both or neither. count never exceeds DEPTH and never goes below 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally.
- wr_ack, overflow and underflow are single-cycle pulses registered one cycle after the request.
- STD mode:
  - On an accepted read, dout updates on the next edge and data_valid pulses high for that cycle.
  - dout holds its value otherwise.
  - empty = (count == 0).
- FWFT mode:
  - Output register holds the head word; empty = output register invalid; data_valid = !empty.
  - A write into a fully empty FIFO appears on dout with empty low on the cycle after the write edge (1-cycle fall-through, bypassing the RAM).
  - On pop, the next word loads from RAM at the same edge. The RAM read is issued from the pointer ahead, so back-to-back pops sustain 1 word/cycle with no bubbles.
  - Simultaneous write and pop with count == 1: the new word moves straight to the output register; empty stays low.
- Throughput: 1 write and 1 read per cycle sustained in both modes.
- Memory: simple dual-port, write-first irrelevant (read and write addresses differ whenever both are used), synchronous read.

Optional Feature:
PIRADIP_SYNC_FIFO_STICKY_ERR_EN
- Defined: adds input err_clr (1 bit) and output err_status (2 bits: [0] overflow seen, [1] underflow seen).
  - Bits set on the corresponding pulse and hold until err_clr is high at a clock edge or reset.
  - When a set and an err_clr occur in the same cycle, the set wins.
- Undefined: ports and logic are absent; overflow and underflow remain pulse-only.

Decomposition:
- Package piradip_fifo_pkg:
  - typedef enum fifo_mode_t {FIFO_STD, FIFO_FWFT}
  - function fifo_cw(depth) returning $clog2(depth)+1
  - localparam checks for power-of-two depth
- Sub-module piradip_sdp_ram: parameters WIDTH and DEPTH; one clock; wr_en/wr_addr/wr_data and rd_en/rd_addr/rd_data; 1-cycle registered read; inferred.
- The FIFO top holds the pointers, count, flag registers and the FWFT output stage.

Test Plan:
- Reset, then with DEPTH=16 and STD: write 0..15 -> full=1 at count 16 and almost_full at 15; a 17th write gives overflow pulse, count stays 16. Read 16 -> dout 0..15 in order, one cycle after each re, with data_valid pulses.
- STD, empty: assert re -> underflow pulses once, count 0, dout unchanged.
- FWFT: single write of 0xA5 into empty -> next cycle empty=0 and dout=0xA5. Pop -> empty=1 the following cycle.
- FWFT: stream 1000 words with we=re=1 continuously after 1 primed word -> no bubbles, count stays 1, output order preserved across pointer wrap.
- When full, assert we and re together -> read accepted, write rejected (overflow), count goes 16 -> 15. Check prog_full/prog_empty crossing at thresholds 14 and 2.
- Pull rstn low mid-stream at count=7 -> all outputs take reset values immediately (async). After release, the first write reads back correctly. With the macro defined, sticky bits set on overflow and clear on err_clr.
